branch_resolve_unit: RTL and testbench

- Resolves conditional branches in E by comparing the D-stage direction prediction with the actual outcome.
- On a misprediction, raises a front-end flush and a corrected-PC redirect toward fetch, using a valid/ready handshake.
- Carries resolved branches into M as the predictor's training strobe (branchM, actual_takeM, pcM).
- Keeps branch and misprediction performance counters.

---
 rtl/branch_resolve_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Resolves E-stage conditional branches against their D-stage
//            prediction, issues flush/redirect on a miss, feeds predictor
//            training into M and keeps saturating branch/mispredict counts.
// Revision : 1.0  initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branchD,
    input  logic             pred_takeD,
    input  logic [31:0]      pcD,
    input  logic [31:0]      targetD,
    input  logic             stallE,
    input  logic             flushE,
    input  logic             stallM,
    input  logic             actual_takeE,
    input  logic             redirect_ready,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_req,
    output logic             branchM,
    output logic             actual_takeM,
    output logic [31:0]      pcM,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_mispred
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PENDING = 1'b1;

    localparam logic [31:0] C_PC_STEP = 32'd4;

    // ------------------------------------------------------------------
    // State and pipeline registers
    // ------------------------------------------------------------------
    logic [0:0]       state_q,       state_d;
    logic [31:0]      pend_pc_q,     pend_pc_d;

    logic             br_v_q,        br_v_d;
    logic             pred_t_q,      pred_t_d;
    logic [31:0]      pc_e_q,        pc_e_d;
    logic [31:0]      tgt_e_q,       tgt_e_d;
    logic [31:0]      pc4_e_q,       pc4_e_d;

    logic             branch_m_q,    branch_m_d;
    logic             act_take_m_q,  act_take_m_d;
    logic [31:0]      pc_m_q,        pc_m_d;

    logic [CNT_W-1:0] cnt_branch_q,  cnt_branch_d;
    logic [CNT_W-1:0] cnt_mispred_q, cnt_mispred_d;

    // ------------------------------------------------------------------
    // Resolution datapath
    // ------------------------------------------------------------------
    logic        w_resolve;
    logic        w_mispred;
    logic        w_counted;
    logic        w_counted_miss;
    logic [31:0] w_correct_pc;

    assign w_resolve      = br_v_q & ~stallE;
    assign w_mispred      = w_resolve & (actual_takeE != pred_t_q);
    // Resolutions are only honoured in IDLE; a stray one while PENDING is dropped.
    assign w_counted      = w_resolve & (state_q == S_IDLE);
    assign w_counted_miss = w_mispred & (state_q == S_IDLE);
    assign w_correct_pc   = actual_takeE ? tgt_e_q : pc4_e_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pend_pc_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            S_IDLE: begin
                if (w_counted_miss && !redirect_ready) begin
                    state_d   = S_PENDING;
                    pend_pc_d = w_correct_pc;
                end
            end
            S_PENDING: begin
                if (redirect_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        flush_req      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_counted_miss) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = w_correct_pc;
                    flush_req      = 1'b1;
                end
            end
            S_PENDING: begin
                redirect_valid = 1'b1;
                redirect_pc    = pend_pc_q;
                flush_req      = 1'b1;
            end
            default: begin
                redirect_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // D->E register
    // ------------------------------------------------------------------
    always_comb begin
        br_v_d    = br_v_q;
        pred_t_d  = pred_t_q;
        pc_e_d    = pc_e_q;
        tgt_e_d   = tgt_e_q;
        pc4_e_d   = pc4_e_q;
        if (flushE || flush_req) begin
            br_v_d = 1'b0;
        end else if (!stallE) begin
            br_v_d    = branchD;
            pred_t_d  = pred_takeD;
            pc_e_d    = pcD;
            tgt_e_d   = targetD;
            pc4_e_d   = pcD + C_PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_v_q   <= 1'b0;
            pred_t_q <= 1'b0;
            pc_e_q   <= 32'd0;
            tgt_e_q  <= 32'd0;
            pc4_e_q  <= 32'd0;
        end else begin
            br_v_q   <= br_v_d;
            pred_t_q <= pred_t_d;
            pc_e_q   <= pc_e_d;
            tgt_e_q  <= tgt_e_d;
            pc4_e_q  <= pc4_e_d;
        end
    end

    // ------------------------------------------------------------------
    // E->M register (predictor training strobe)
    // ------------------------------------------------------------------
    always_comb begin
        branch_m_d   = branch_m_q;
        act_take_m_d = act_take_m_q;
        pc_m_d       = pc_m_q;
        if (!stallM) begin
            branch_m_d   = w_counted;
            act_take_m_d = actual_takeE;
            pc_m_d       = pc_e_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_m_q   <= 1'b0;
            act_take_m_q <= 1'b0;
            pc_m_q       <= 32'd0;
        end else begin
            branch_m_q   <= branch_m_d;
            act_take_m_q <= act_take_m_d;
            pc_m_q       <= pc_m_d;
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_comb begin
        cnt_branch_d  = cnt_branch_q;
        cnt_mispred_d = cnt_mispred_q;
        if (w_counted && !(&cnt_branch_q)) begin
            cnt_branch_d = cnt_branch_q + CNT_W'(1);
        end
        if (w_counted_miss && !(&cnt_mispred_q)) begin
            cnt_mispred_d = cnt_mispred_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_branch_q  <= '0;
            cnt_mispred_q <= '0;
        end else begin
            cnt_branch_q  <= cnt_branch_d;
            cnt_mispred_q <= cnt_mispred_d;
        end
    end

    assign branchM      = branch_m_q;
    assign actual_takeM = act_take_m_q;
    assign pcM          = pc_m_q;
    assign cnt_branch   = cnt_branch_q;
    assign cnt_mispred  = cnt_mispred_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Directed self-checking bench for branch_resolve_unit (32-bit and
//            4-bit counter instances driven from the same stimulus).
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        branchD;
    logic        pred_takeD;
    logic [31:0] pcD;
    logic [31:0] targetD;
    logic        stallE;
    logic        flushE;
    logic        stallM;
    logic        actual_takeE;
    logic        redirect_ready;

    logic        redirect_valid,  redirect_valid4;
    logic [31:0] redirect_pc,     redirect_pc4;
    logic        flush_req,       flush_req4;
    logic        branchM,         branchM4;
    logic        actual_takeM,    actual_takeM4;
    logic [31:0] pcM,             pcM4;
    logic [31:0] cnt_branch,      cnt_mispred;
    logic [3:0]  cnt_branch4,     cnt_mispred4;

    int n_checks;
    int n_fail;

    branch_resolve_unit #(.CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .branchD(branchD), .pred_takeD(pred_takeD),
        .pcD(pcD), .targetD(targetD), .stallE(stallE), .flushE(flushE),
        .stallM(stallM), .actual_takeE(actual_takeE),
        .redirect_ready(redirect_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush_req(flush_req), .branchM(branchM),
        .actual_takeM(actual_takeM), .pcM(pcM), .cnt_branch(cnt_branch),
        .cnt_mispred(cnt_mispred)
    );

    branch_resolve_unit #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .branchD(branchD), .pred_takeD(pred_takeD),
        .pcD(pcD), .targetD(targetD), .stallE(stallE), .flushE(flushE),
        .stallM(stallM), .actual_takeE(actual_takeE),
        .redirect_ready(redirect_ready), .redirect_valid(redirect_valid4),
        .redirect_pc(redirect_pc4), .flush_req(flush_req4), .branchM(branchM4),
        .actual_takeM(actual_takeM4), .pcM(pcM4), .cnt_branch(cnt_branch4),
        .cnt_mispred(cnt_mispred4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Present one branch in D for a single cycle.
    task automatic issue(input logic pred, input logic [31:0] pc, input logic [31:0] tgt);
        branchD    = 1'b1;
        pred_takeD = pred;
        pcD        = pc;
        targetD    = tgt;
        tick();
        branchD    = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; branchD = 1'b0; pred_takeD = 1'b0; pcD = 32'd0; targetD = 32'd0;
        stallE = 1'b0; flushE = 1'b0; stallM = 1'b0; actual_takeE = 1'b0;
        redirect_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk_eq("rst_valid",   32'(redirect_valid), 32'd0);
        chk_eq("rst_flush",   32'(flush_req),      32'd0);
        chk_eq("rst_branchM", 32'(branchM),        32'd0);
        chk_eq("rst_pcM",     pcM,                 32'd0);
        chk_eq("rst_cntb",    cnt_branch,          32'd0);
        chk_eq("rst_cntm",    cnt_mispred,         32'd0);

        // Correct prediction: training strobe only
        issue(1'b1, 32'h100, 32'h200);
        actual_takeE = 1'b1;
        settle();
        chk_eq("ok_flush", 32'(flush_req),      32'd0);
        chk_eq("ok_valid", 32'(redirect_valid), 32'd0);
        tick();
        chk_eq("ok_branchM", 32'(branchM),      32'd1);
        chk_eq("ok_takeM",   32'(actual_takeM), 32'd1);
        chk_eq("ok_pcM",     pcM,               32'h100);
        chk_eq("ok_cntb",    cnt_branch,        32'd1);
        chk_eq("ok_cntm",    cnt_mispred,       32'd0);
        tick();
        chk_eq("ok_branchM_drop", 32'(branchM), 32'd0);

        // Mispredict with ready high: one-cycle redirect to pc+4
        issue(1'b1, 32'h100, 32'h200);
        actual_takeE = 1'b0;
        redirect_ready = 1'b1;
        settle();
        chk_eq("mr_valid", 32'(redirect_valid), 32'd1);
        chk_eq("mr_pc",    redirect_pc,         32'h104);
        chk_eq("mr_flush", 32'(flush_req),      32'd1);
        tick();
        chk_eq("mr_valid_drop", 32'(redirect_valid), 32'd0);
        chk_eq("mr_branchM",    32'(branchM),        32'd1);
        chk_eq("mr_takeM",      32'(actual_takeM),   32'd0);
        chk_eq("mr_cntb",       cnt_branch,          32'd2);
        chk_eq("mr_cntm",       cnt_mispred,         32'd1);

        // Mispredict with ready low for 3 cycles: redirect held 4 cycles
        issue(1'b0, 32'h300, 32'h40);
        actual_takeE = 1'b1;
        redirect_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) redirect_ready = 1'b1;
            settle();
            chk_eq("pend_valid", 32'(redirect_valid), 32'd1);
            chk_eq("pend_pc",    redirect_pc,         32'h40);
            chk_eq("pend_flush", 32'(flush_req),      32'd1);
            tick();
            actual_takeE = 1'b0;
            targetD      = 32'hDEAD_0000;
        end
        chk_eq("pend_release_valid", 32'(redirect_valid), 32'd0);
        chk_eq("pend_release_flush", 32'(flush_req),      32'd0);
        chk_eq("pend_cntb",          cnt_branch,          32'd3);
        chk_eq("pend_cntm",          cnt_mispred,         32'd2);

        // Stalled mispredicting branch resolves once after release
        issue(1'b1, 32'h500, 32'h600);
        actual_takeE = 1'b0;
        stallE = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk_eq("stall_valid", 32'(redirect_valid), 32'd0);
            tick();
            chk_eq("stall_branchM", 32'(branchM), 32'd0);
        end
        stallE = 1'b0;
        settle();
        chk_eq("stall_rel_valid", 32'(redirect_valid), 32'd1);
        chk_eq("stall_rel_pc",    redirect_pc,         32'h504);
        tick();
        chk_eq("stall_once_valid", 32'(redirect_valid), 32'd0);
        chk_eq("stall_branchM",    32'(branchM),        32'd1);
        chk_eq("stall_cntb",       cnt_branch,          32'd4);
        chk_eq("stall_cntm",       cnt_mispred,         32'd3);

        // flushE concurrent with mispredict: redirect still issued
        issue(1'b0, 32'h700, 32'h800);
        branchD = 1'b1; pcD = 32'h900; flushE = 1'b1; actual_takeE = 1'b1;
        settle();
        chk_eq("fl_valid", 32'(redirect_valid), 32'd1);
        chk_eq("fl_pc",    redirect_pc,         32'h800);
        tick();
        branchD = 1'b0; flushE = 1'b0;
        chk_eq("fl_cntm", cnt_mispred, 32'd4);

        // flushE alone squashes the branch being loaded
        branchD = 1'b1; pred_takeD = 1'b0; pcD = 32'hA00; targetD = 32'hB00; flushE = 1'b1;
        tick();
        branchD = 1'b0; flushE = 1'b0; actual_takeE = 1'b1;
        settle();
        chk_eq("sq_valid", 32'(redirect_valid), 32'd0);
        tick();
        chk_eq("sq_branchM", 32'(branchM),   32'd0);
        chk_eq("sq_cntb",    cnt_branch,     32'd5);

        // pc+4 wraps at the top of the address space
        issue(1'b1, 32'hFFFF_FFFC, 32'h1000);
        actual_takeE = 1'b0;
        settle();
        chk_eq("wrap_valid", 32'(redirect_valid), 32'd1);
        chk_eq("wrap_pc",    redirect_pc,         32'h0);
        tick();

        // Reset while PENDING
        issue(1'b1, 32'h2000, 32'h3000);
        actual_takeE = 1'b0;
        redirect_ready = 1'b0;
        tick();
        settle();
        chk_eq("rp_pending_valid", 32'(redirect_valid), 32'd1);
        chk_eq("rp_pending_pc",    redirect_pc,         32'h2004);
        rst = 1'b1;
        tick();
        chk_eq("rp_valid",   32'(redirect_valid), 32'd0);
        chk_eq("rp_flush",   32'(flush_req),      32'd0);
        chk_eq("rp_cntb",    cnt_branch,          32'd0);
        chk_eq("rp_cntm",    cnt_mispred,         32'd0);
        chk_eq("rp_branchM", 32'(branchM),        32'd0);
        rst = 1'b0;
        redirect_ready = 1'b1;
        settle();
        chk_eq("rp_after_valid", 32'(redirect_valid), 32'd0);

        // 17 mispredictions: 4-bit counters saturate at 15
        for (int b = 0; b < 17; b++) begin
            issue(1'b0, 32'h4000 + 32'(b) * 32'd8, 32'h8000);
            actual_takeE = 1'b1;
            tick();
            actual_takeE = 1'b0;
        end
        chk_eq("sat_cntb4", 32'(cnt_branch4),  32'd15);
        chk_eq("sat_cntm4", 32'(cnt_mispred4), 32'd15);
        chk_eq("sat_cntb",  cnt_branch,        32'd17);
        chk_eq("sat_cntm",  cnt_mispred,       32'd17);
        issue(1'b0, 32'h5000, 32'h9000);
        actual_takeE = 1'b1;
        tick();
        actual_takeE = 1'b0;
        chk_eq("sat_hold_b4", 32'(cnt_branch4),  32'd15);
        chk_eq("sat_hold_m4", 32'(cnt_mispred4), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
